// File: rtl/system_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : system_bus_arbiter
//  Description : Round-robin arbiter sharing the system_bus master port
//                between N requesters. It latches the winner's request onto
//                the bus and holds it until the bus drops busy or a WAIT
//                timeout aborts the access. It then returns read data and an
//                error flag to the winner with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module system_bus_arbiter #(
    parameter int N_MASTERS = 3,
    parameter int TIMEOUT   = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      r_req,
    input  logic [N_MASTERS-1:0]      r_we,
    input  logic [32*N_MASTERS-1:0]   r_addr,
    input  logic [32*N_MASTERS-1:0]   r_wdata,
    input  logic [3*N_MASTERS-1:0]    r_size,
    output logic [N_MASTERS-1:0]      r_gnt,
    output logic [N_MASTERS-1:0]      r_done,
    output logic [31:0]               r_rdata,
    output logic                      r_error,
    output logic [31:0]               b_addr,
    output logic [31:0]               b_wdata,
    output logic [2:0]                b_size,
    output logic                      b_read,
    output logic                      b_write,
    input  logic [31:0]               b_rdata,
    input  logic                      b_busy,
    input  logic                      b_error,
    output logic                      timeout
);

    localparam int          c_ptr_w      = $clog2(N_MASTERS);
    localparam int          c_cnt_w      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int          c_to_last    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [31:0] c_abort_data = 32'hDEAD_0BAD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_cnt_w-1:0]   r_wait_cnt;
    logic [c_ptr_w-1:0]   w_winner;
    int                   w_best;
    int                   w_dist;

    // Round-robin pick: the active request closest after the last winner wins.
    always_comb begin
        w_winner = '0;
        w_best   = N_MASTERS;
        w_dist   = 0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_dist = (i + N_MASTERS - 1 - int'(r_ptr)) % N_MASTERS;
            if (r_req[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = c_ptr_w'(i);
            end
        end
    end

    // Arbitration FSM; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= c_ptr_w'(N_MASTERS - 1);
            r_wait_cnt <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
            b_addr     <= '0;
            b_wdata    <= '0;
            b_size     <= '0;
            b_read     <= 1'b0;
            b_write    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_done  <= '0;
            timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|r_req) begin
                        b_addr  <= r_addr[32*w_winner +: 32];
                        b_wdata <= r_wdata[32*w_winner +: 32];
                        b_size  <= r_size[3*w_winner +: 3];
                        b_read  <= ~r_we[w_winner];
                        b_write <= r_we[w_winner];
                        r_gnt   <= N_MASTERS'(1) << w_winner;
                        r_ptr   <= w_winner;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The bus registers its response, so busy is not looked at yet.
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!b_busy) begin
                        r_rdata <= b_rdata;
                        r_error <= b_error;
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        b_read  <= 1'b0;
                        b_write <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (r_wait_cnt == c_cnt_w'(c_to_last))) begin
                        r_rdata <= c_abort_data;
                        r_error <= 1'b1;
                        r_done  <= r_gnt;
                        timeout <= 1'b1;
                        r_gnt   <= '0;
                        b_read  <= 1'b0;
                        b_write <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
